compare_swap_stage: RTL
=======================

Name: compare_swap_stage

Overview:
- One pipelined compare-and-swap element of the sorting network in the fixed-weight (t-small) polynomial sampler.
- Consumes a pair of WIDTH-bit random keys, instantiates the combinational comparator and emits the pair ordered min/max (or max/min).
- Also tracks duplicate keys per frame, so the downstream sampler can reject frames containing collisions.
- Uses a ready/valid handshake on both sides and a 2-entry skid buffer, giving full throughput under backpressure.

Parameters:
- WIDTH, 32, key width in bits; must be even (comparator splits keys in halves).
- ASCENDING, 1, 1: out_lo gets the smaller key; 0: out_lo gets the larger key.
- CNT_W, 8, width of the saturating per-frame duplicate counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept a pair.
- in_a  in  WIDTH  left key.
- in_b  in  WIDTH  right key.
- in_last  in  1  pair is the last of a frame.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts.
- out_lo  out  WIDTH  first ordered key.
- out_hi  out  WIDTH  second ordered key.
- out_swapped  out  1  the pair was exchanged relative to input order.
- out_dup  out  1  in_a == in_b for this pair.
- out_last  out  1  registered in_last.
- frame_dup_cnt  out  CNT_W  duplicates seen in the frame, including this pair; meaningful when out_last=1.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=0 while asserted; both skid entries empty; frame accumulator cleared.
  - All data outputs reset to 0: out_lo, out_hi, out_swapped, out_dup, out_last, frame_dup_cnt.
  - First cycle after deassertion: in_ready=1.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready.
- Swap rule: swap = ASCENDING ? (in_b < in_a) : (in_a < in_b).
  - Computed as comparator(L=in_b, R=in_a).L_smaller, or comparator(L=in_a, R=in_b).L_smaller respectively.
  - Equal keys: no swap; out_dup=1.
  - Compare is unsigned over the full WIDTH.
- Latency: a pair accepted at edge N appears on the outputs after edge N (out_valid=1 from cycle N+1) when the main register is free.
- Skid buffer: main register M (drives outputs) plus skid register S.
  - in_ready = !S_valid, registered; no combinational path from out_ready to in_ready.
  - M empty, or M transferring this cycle: the accepted pair goes to M (or S moves to M and the new pair goes to S).
  - M full and held (out_ready=0): the accepted pair goes to S and in_ready drops the next cycle.
  - Order is strictly FIFO; simultaneous in and out transfers with S empty keep S empty (throughput 1 pair/cycle).
- Output stability: while out_valid=1 and out_ready=0, all out_* and frame_dup_cnt hold.
- Duplicate accounting, performed at input acceptance:
  - acc_next = sat(acc + dup).
  - The pair stores frame_dup_cnt = acc_next.
  - If in_last=1, acc resets to 0 after that pair; otherwise acc = acc_next.
  - Saturation at 2^CNT_W-1; no wrap-around.
- Frames without in_last simply keep accumulating, saturating.
- Reset mid-frame or mid-stall: all buffered pairs are discarded and the accumulator is cleared; no output is produced for them.
- No X propagation: data registers load only on acceptance.

Decomposition:
- Shared package sort_pkg:
  - constants KEY_WIDTH=32, DUP_CNT_W=8;
  - typedef pair_t = {lo, hi, swapped, dup, last, cnt} used by M and S and by neighbouring network stages.
- One sub-module: the existing comparator `compare` (WIDTH passed through), instantiated once.
- Skid logic stays inline in compare_swap_stage.

Test Plan:
- Ascending, in_a=0x0000_0005, in_b=0x0000_0003, out_ready=1 -> next cycle out_lo=3, out_hi=5, out_swapped=1, out_dup=0.
- Half-boundary compare, in_a=0x0001_0000, in_b=0x0000_FFFF, ASCENDING=0 -> out_lo=0x0001_0000, out_swapped=0.
- Same pair with ASCENDING=1 -> out_lo=0x0000_FFFF, out_swapped=1.
- Frame of 4 pairs with keys equal in pairs 2 and 4, in_last on pair 4 -> out_dup=0,1,0,1 and frame_dup_cnt=0,1,1,2.
- Next frame restarts at 0.
- Backpressure: stream 6 pairs with out_ready=0 for cycles 2-5 -> in_ready low from cycle 3.
  - Outputs hold stable while stalled.
  - All 6 pairs emerge in order with no loss or duplication.
  - Back-to-back throughput of 1 pair/cycle resumes after the stall.
- Saturation, CNT_W=2: 5 equal pairs, in_last on the 5th -> frame_dup_cnt=1,2,3,3,3.
- Reset: assert rst_n=0 during a stall with both entries full -> out_valid=0 immediately (async).
  - After release, in_ready=1, the accumulator is 0, and no stale pair is emitted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and constants for the fixed-weight sampler sorting network.
package sort_pkg;

  localparam int unsigned KEY_WIDTH = 32;
  localparam int unsigned DUP_CNT_W = 8;

  // One ordered pair as it travels between network stages. Narrower stages
  // zero-extend their keys and counts into these fields.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] lo;
    logic [KEY_WIDTH-1:0] hi;
    logic                 swapped;
    logic                 dup;
    logic                 last;
    logic [DUP_CNT_W-1:0] cnt;
  } pair_t;

endpackage

// File: rtl/compare.sv
// Combinational unsigned comparator. Each key is split into two halves so
// that the two narrower compares can run in parallel.
module compare #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] l,
  input  logic [WIDTH-1:0] r,
  output logic             l_smaller,
  output logic             equal
);

  localparam int unsigned HALF = WIDTH / 2;

  logic hi_lt;
  logic hi_eq;
  logic lo_lt;
  logic lo_eq;

  // Upper half decides unless it ties; then the lower half decides.
  always_comb begin
    hi_lt     = l[WIDTH-1:HALF] < r[WIDTH-1:HALF];
    hi_eq     = l[WIDTH-1:HALF] == r[WIDTH-1:HALF];
    lo_lt     = l[HALF-1:0] < r[HALF-1:0];
    lo_eq     = l[HALF-1:0] == r[HALF-1:0];
    l_smaller = hi_lt | (hi_eq & lo_lt);
    equal     = hi_eq & lo_eq;
  end

endmodule

// File: rtl/compare_swap_stage.sv
// Pipelined compare-and-swap element with a 2-entry skid buffer and
// per-frame duplicate-key counting. WIDTH must not exceed KEY_WIDTH and
// CNT_W must not exceed DUP_CNT_W, since pairs are stored as pair_t.
module compare_swap_stage
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH     = KEY_WIDTH,
  parameter bit          ASCENDING = 1'b1,
  parameter int unsigned CNT_W     = DUP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_swapped,
  output logic             out_dup,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_dup_cnt
);

  logic [WIDTH-1:0] cmp_l;
  logic [WIDTH-1:0] cmp_r;
  logic             swap;
  logic             keys_eq;

  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_next;
  pair_t            new_pair;

  pair_t m_q;
  pair_t s_q;
  logic  m_valid_q;
  logic  s_valid_q;
  logic  in_ready_q;

  logic in_fire;
  logic m_free;
  logic m_load_s;
  logic m_load_in;
  logic s_load_in;
  logic m_valid_nxt;
  logic s_valid_nxt;

  // Operand order selects which key must be smaller to trigger a swap.
  always_comb begin
    cmp_l = ASCENDING ? in_b : in_a;
    cmp_r = ASCENDING ? in_a : in_b;
  end

  compare #(.WIDTH(WIDTH)) u_compare (
    .l         (cmp_l),
    .r         (cmp_r),
    .l_smaller (swap),
    .equal     (keys_eq)
  );

  // Build the ordered pair and its saturating frame duplicate count.
  always_comb begin
    acc_next = (keys_eq && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
    new_pair         = '0;
    new_pair.lo      = KEY_WIDTH'(swap ? in_b : in_a);
    new_pair.hi      = KEY_WIDTH'(swap ? in_a : in_b);
    new_pair.swapped = swap;
    new_pair.dup     = keys_eq;
    new_pair.last    = in_last;
    new_pair.cnt     = DUP_CNT_W'(acc_next);
  end

  // Skid routing: M refills from S first so ordering stays FIFO; a new pair
  // only lands in S when M is occupied and not draining this cycle.
  always_comb begin
    in_fire     = in_valid && in_ready_q;
    m_free      = !m_valid_q || out_ready;
    m_load_s    = m_free && s_valid_q;
    m_load_in   = m_free && !s_valid_q && in_fire;
    s_load_in   = in_fire && !m_load_in;
    m_valid_nxt = m_free ? (s_valid_q || in_fire) : 1'b1;
    if (s_load_in) begin
      s_valid_nxt = 1'b1;
    end else if (m_load_s) begin
      s_valid_nxt = 1'b0;
    end else begin
      s_valid_nxt = s_valid_q;
    end
  end

  // Occupancy flags and the registered ready, which mirrors an empty S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_nxt;
      s_valid_q  <= s_valid_nxt;
      in_ready_q <= !s_valid_nxt;
    end
  end

  // Pair storage and accumulator load only on actual transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      s_q   <= '0;
      acc_q <= '0;
    end else begin
      if (m_load_s) begin
        m_q <= s_q;
      end else if (m_load_in) begin
        m_q <= new_pair;
      end
      if (s_load_in) begin
        s_q <= new_pair;
      end
      if (in_fire) begin
        acc_q <= in_last ? '0 : acc_next;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = m_valid_q;
  assign out_lo        = m_q.lo[WIDTH-1:0];
  assign out_hi        = m_q.hi[WIDTH-1:0];
  assign out_swapped   = m_q.swapped;
  assign out_dup       = m_q.dup;
  assign out_last      = m_q.last;
  assign frame_dup_cnt = m_q.cnt[CNT_W-1:0];

endmodule
